// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset domain sequencer: FSM states,
// index sizing and software-request priority encoding.
package reset_seq_pkg;

  localparam int MAX_DOMAINS = 16;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_STABLE,
    ST_RELEASE,
    ST_WAIT_READY,
    ST_GAP,
    ST_RUN,
    ST_ERROR
  } seq_state_e;

  // Width of a domain index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set bit, 0 when no bit is set.
  function automatic int lowest_set(input logic [MAX_DOMAINS-1:0] v);
    int pos;
    pos = 0;
    for (int i = MAX_DOMAINS - 1; i >= 0; i--) begin
      if (v[i]) pos = i;
    end
    return pos;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchroniser for asynchronous level inputs; both stages
// clear to 0 on reset so nothing is seen as locked or ready early.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make sync_q take the pre-edge meta_q, giving two real stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_domain_sequencer.sv
// Releases fabric reset domains one by one after PLL lock is stable,
// waiting for each domain's ready acknowledge and a gap before the next.
module reset_domain_sequencer
  import reset_seq_pkg::*;
#(
  parameter  int NUM_DOMAINS = 4,
  parameter  int STAGE_DELAY = 16,
  parameter  int ACK_TIMEOUT = 255,
  parameter  int CNT_W       = 8,
  localparam int IDX_W       = idx_width(NUM_DOMAINS)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   PLL_LOCK,
  input  logic [NUM_DOMAINS-1:0] DOMAIN_READY,
  input  logic [NUM_DOMAINS-1:0] SW_RST_REQ,
  input  logic                   RETRY,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
  output logic                   SEQ_DONE,
  output logic                   SEQ_ERROR,
  output logic [IDX_W-1:0]       ERR_DOMAIN
);

  localparam logic [CNT_W-1:0] STAGE_CNT = CNT_W'(STAGE_DELAY);
  localparam logic [CNT_W-1:0] ACK_CNT   = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_DOMAINS-1:0] dom_rst_n_q;
  logic                   seq_done_q;
  logic                   seq_error_q;
  logic [IDX_W-1:0]       err_domain_q;

  logic                   lock_s;
  logic [NUM_DOMAINS-1:0] rdy_s;
  logic [IDX_W-1:0]       sw_idx;
  logic [CNT_W-1:0]       cnt_dec;
  logic [NUM_DOMAINS-1:0] idx_onehot;
  logic [NUM_DOMAINS-1:0] upper_mask;
  logic [NUM_DOMAINS-1:0] sw_mask;
  logic                   lock_lost;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d_i   (PLL_LOCK),
    .q_o   (lock_s)
  );

  sync_2ff #(.WIDTH(NUM_DOMAINS)) u_rdy_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d_i   (DOMAIN_READY),
    .q_o   (rdy_s)
  );

  assign sw_idx    = IDX_W'(lowest_set(MAX_DOMAINS'(SW_RST_REQ)));
  assign cnt_dec   = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;
  assign lock_lost = !lock_s && (state_q != ST_HOLD) && (state_q != ST_ERROR);

  // NOTE: every output of this block gets a default before the loop, so no latch is inferred.
  always_comb begin
    idx_onehot = '0;
    upper_mask = '0;
    sw_mask    = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      idx_onehot[i] = (IDX_W'(i) == idx_q);
      upper_mask[i] = (IDX_W'(i) >= idx_q);
      sw_mask[i]    = (IDX_W'(i) >= sw_idx);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_HOLD;
      idx_q        <= '0;
      cnt_q        <= '0;
      dom_rst_n_q  <= '0;
      seq_done_q   <= 1'b0;
      seq_error_q  <= 1'b0;
      err_domain_q <= '0;
    end else if (lock_lost) begin
      state_q     <= ST_HOLD;
      idx_q       <= '0;
      cnt_q       <= '0;
      dom_rst_n_q <= '0;
      seq_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          dom_rst_n_q <= dom_rst_n_q & ~upper_mask;
          if (lock_s) begin
            cnt_q   <= STAGE_CNT;
            state_q <= ST_STABLE;
          end
        end
        ST_STABLE: begin
          cnt_q <= cnt_dec;
          if (cnt_q <= CNT_ONE) state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          dom_rst_n_q <= dom_rst_n_q | idx_onehot;
          cnt_q       <= ACK_CNT;
          state_q     <= ST_WAIT_READY;
        end
        ST_WAIT_READY: begin
          // A ready seen on the same cycle as expiry still counts as an acknowledge.
          if (rdy_s[idx_q]) begin
            cnt_q   <= STAGE_CNT;
            state_q <= ST_GAP;
          end else if (cnt_q <= CNT_ONE) begin
            cnt_q        <= '0;
            dom_rst_n_q  <= dom_rst_n_q & ~idx_onehot;
            seq_error_q  <= 1'b1;
            err_domain_q <= idx_q;
            state_q      <= ST_ERROR;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        ST_GAP: begin
          cnt_q <= cnt_dec;
          if (cnt_q <= CNT_ONE) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_RUN;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_RELEASE;
            end
          end
        end
        ST_RUN: begin
          if (|SW_RST_REQ) begin
            dom_rst_n_q <= dom_rst_n_q & ~sw_mask;
            seq_done_q  <= 1'b0;
            idx_q       <= sw_idx;
            cnt_q       <= STAGE_CNT;
            state_q     <= ST_STABLE;
          end else begin
            seq_done_q <= 1'b1;
          end
        end
        ST_ERROR: begin
          // Lock loss drops every domain but keeps the error report for software.
          if (!lock_s) begin
            dom_rst_n_q <= '0;
          end else if (RETRY) begin
            dom_rst_n_q <= '0;
            seq_error_q <= 1'b0;
            idx_q       <= '0;
            state_q     <= ST_HOLD;
          end
        end
        default: state_q <= ST_HOLD;
      endcase
    end
  end

  assign DOMAIN_RESET_N = dom_rst_n_q;
  assign SEQ_DONE       = seq_done_q;
  assign SEQ_ERROR      = seq_error_q;
  assign ERR_DOMAIN     = err_domain_q;

endmodule

// File: tb/tb_reset_domain_sequencer.sv
// Scoreboard bench for reset_domain_sequencer: stimulus queues the expected
// output changes with latency windows, a monitor compares each change it sees.
module tb_reset_domain_sequencer;

  localparam int N  = 4;
  localparam int SD = 16;
  localparam int AT = 64;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         PLL_LOCK;
  logic [N-1:0] DOMAIN_READY;
  logic [N-1:0] SW_RST_REQ;
  logic         RETRY;
  logic [N-1:0] DOMAIN_RESET_N;
  logic         SEQ_DONE;
  logic         SEQ_ERROR;
  logic [1:0]   ERR_DOMAIN;

  reset_domain_sequencer #(
    .NUM_DOMAINS (N),
    .STAGE_DELAY (SD),
    .ACK_TIMEOUT (AT),
    .CNT_W       (8)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .PLL_LOCK       (PLL_LOCK),
    .DOMAIN_READY   (DOMAIN_READY),
    .SW_RST_REQ     (SW_RST_REQ),
    .RETRY          (RETRY),
    .DOMAIN_RESET_N (DOMAIN_RESET_N),
    .SEQ_DONE       (SEQ_DONE),
    .SEQ_ERROR      (SEQ_ERROR),
    .ERR_DOMAIN     (ERR_DOMAIN)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [3:0] rst;
    logic       done;
    logic       err;
    logic [1:0] dom;
    bit         use_mark;  // latency measured from a stimulus edge, else from the previous change
    int         mark;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         m;
  logic [N-1:0] stuck = '0;
  int         age[N];
  logic [7:0] mon_prev;
  bit         mon_first = 1'b1;
  int         mon_last  = 0;

  function automatic logic [7:0] pack(input exp_t e);
    return {e.rst, e.done, e.err, e.dom};
  endfunction

  task automatic check(input string name, input int act, input int lo, input int hi, input bit hex_fmt);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      if (hex_fmt)
        $display("FAIL %s: got {rst,done,err,dom}=0x%02h, expected 0x%02h (cycle %0d)", name, act, lo, cyc);
      else
        $display("FAIL %s: got %0d cycles, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic expect_evt(input string name, input logic [3:0] rst, input logic done,
                            input logic err, input logic [1:0] dom, input bit use_mark,
                            input int mark, input int lo, input int hi);
    exp_t e;
    e.name = name; e.rst = rst; e.done = done; e.err = err; e.dom = dom;
    e.use_mark = use_mark; e.mark = mark; e.lo = lo; e.hi = hi;
    sb_q.push_back(e);
  endtask

  // Releases of domains from..N-1 spaced by ready latency plus gap, then SEQ_DONE.
  task automatic seq_tail(input string tag, input int from, input logic [1:0] edom);
    for (int d = from; d < N; d++)
      expect_evt($sformatf("%s dom%0d release", tag, d), 4'((1 << (d + 1)) - 1), 1'b0, 1'b0, edom, 1'b0, 0, 24, 26);
    expect_evt($sformatf("%s done", tag), 4'hF, 1'b1, 1'b0, edom, 1'b0, 0, 24, 26);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic goto_cyc(input int n);
    do @(negedge CLK); while (cyc < n);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (sb_q.size() != 0) begin
      check({name, " pending expectations"}, sb_q.size(), 0, 0, 1'b0);
      sb_q.delete();
    end
  endtask

  // Domain model: ready rises 5 cycles after its reset releases, drops with reset.
  initial begin
    DOMAIN_READY = '0;
    for (int i = 0; i < N; i++) age[i] = 0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        if (DOMAIN_RESET_N[i] === 1'b1) age[i] = (age[i] < 1000) ? age[i] + 1 : age[i];
        else age[i] = 0;
        DOMAIN_READY[i] = (age[i] >= 5) && !stuck[i];
      end
    end
  end

  // Monitor: every change of the output tuple consumes one expectation.
  initial begin
    logic [7:0] cur;
    exp_t e;
    int base;
    forever begin
      @(negedge CLK);
      cur = {DOMAIN_RESET_N, SEQ_DONE, SEQ_ERROR, ERR_DOMAIN};
      if (mon_first || cur !== mon_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected output change", int'(cur), int'(mon_prev), int'(mon_prev), 1'b1);
        end else begin
          e = sb_q.pop_front();
          check({e.name, " value"}, int'(cur), int'(pack(e)), int'(pack(e)), 1'b1);
          base = e.use_mark ? e.mark : mon_last;
          check({e.name, " latency"}, cyc - base, e.lo, e.hi, 1'b0);
        end
        mon_last  = cyc;
        mon_prev  = cur;
        mon_first = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N    = 1'b1;
    PLL_LOCK   = 1'b0;
    SW_RST_REQ = '0;
    RETRY      = 1'b0;
    #1 RESET_N = 1'b0;
    expect_evt("reset state", 4'h0, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0, 10);
    goto_cyc(2);
    RESET_N = 1'b1;

    // Power-up: lock sampled at edge 10, domain 0 expected near cycle 30.
    goto_cyc(9);
    PLL_LOCK = 1'b1; m = cyc + 1;
    expect_evt("pwr dom0 release", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, m, 19, 21);
    seq_tail("pwr", 1, 2'd0);
    wait_drain("power-up", 400);

    // Software reset of domains 1 and 2 re-sequences from domain 1.
    tick(5);
    SW_RST_REQ = 4'b0110; m = cyc + 1;
    expect_evt("sw reset assert", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, m, 0, 0);
    expect_evt("sw dom1 release", 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0, 0, 17, 18);
    seq_tail("sw", 2, 2'd0);
    tick(1);
    SW_RST_REQ = '0;
    wait_drain("sw reset", 400);

    // Lock loss in RUN while a SW request arrives on the same cycle.
    tick(5);
    PLL_LOCK = 1'b0; m = cyc + 1;
    expect_evt("lock loss run", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, m, 2, 2);
    tick(2);
    SW_RST_REQ = 4'b0100;
    tick(1);
    SW_RST_REQ = '0;
    wait_drain("lock loss", 50);
    tick(20);

    // Lock glitch: 8 high, 1 low, then high; the debounce must restart.
    PLL_LOCK = 1'b1; m = cyc + 1;
    expect_evt("glitch dom0 release", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, m, 27, 29);
    seq_tail("glitch", 1, 2'd0);
    tick(8);
    PLL_LOCK = 1'b0;
    tick(1);
    PLL_LOCK = 1'b1;
    wait_drain("glitch", 400);

    // Timeout on domain 2.
    tick(5);
    PLL_LOCK = 1'b0; m = cyc + 1;
    expect_evt("lock loss pre-timeout", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, m, 2, 2);
    wait_drain("lock loss 2", 50);
    tick(5);
    stuck = 4'b0100;
    PLL_LOCK = 1'b1; m = cyc + 1;
    expect_evt("to dom0 release", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, m, 19, 21);
    expect_evt("to dom1 release", 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0, 0, 24, 26);
    expect_evt("to dom2 release", 4'b0111, 1'b0, 1'b0, 2'd0, 1'b0, 0, 24, 26);
    expect_evt("timeout error", 4'b0011, 1'b0, 1'b1, 2'd2, 1'b0, 0, 64, 65);
    wait_drain("timeout", 400);
    tick(20);

    // Lock loss in ERROR clears resets but keeps the error report.
    PLL_LOCK = 1'b0; m = cyc + 1;
    expect_evt("lock loss in error", 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, m, 2, 2);
    wait_drain("lock loss error", 50);
    PLL_LOCK = 1'b1;
    tick(10);
    stuck = '0;
    RETRY = 1'b1; m = cyc + 1;
    expect_evt("retry clear", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, m, 0, 0);
    expect_evt("retry dom0 release", 4'b0001, 1'b0, 1'b0, 2'd2, 1'b0, 0, 18, 19);
    seq_tail("retry", 1, 2'd2);
    tick(1);
    RETRY = 1'b0;
    tick(3);
    SW_RST_REQ = 4'b1111;
    tick(1);
    SW_RST_REQ = '0;
    wait_drain("retry", 400);
    tick(5);
    RETRY = 1'b1;
    tick(1);
    RETRY = 1'b0;
    tick(20);

    // RESET_N asserted while waiting for domain 1's ready.
    PLL_LOCK = 1'b0; m = cyc + 1;
    expect_evt("lock loss pre-reset", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, m, 2, 2);
    wait_drain("lock loss 3", 50);
    tick(5);
    PLL_LOCK = 1'b1; m = cyc + 1;
    expect_evt("rst dom0 release", 4'b0001, 1'b0, 1'b0, 2'd2, 1'b1, m, 19, 21);
    expect_evt("rst dom1 release", 4'b0011, 1'b0, 1'b0, 2'd2, 1'b0, 0, 24, 26);
    wait_drain("pre-reset", 200);
    @(posedge CLK);
    #2;
    expect_evt("async reset", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, cyc, 0, 0);
    RESET_N = 1'b0;
    tick(3);
    RESET_N = 1'b1; m = cyc + 1;
    expect_evt("post-reset dom0 release", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, m, 19, 21);
    seq_tail("post-reset", 1, 2'd0);
    wait_drain("post-reset", 400);
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
